// File: rtl/hand_display_mux.sv
// hand_display_mux
// Time-multiplexed seven-segment driver for a binary hand total.
// A load strobe captures the total. A serial double-dabble converter then
// produces BCD at one bit per clock. The digits are scanned one slot per
// REFRESH_DIV clocks, with leading-zero blanking and a dash pattern on
// overflow.
//
// Optional feature macro: HAND_BUST_BLINK_EN.
// When it is defined, totals above BUST_LIMIT blink. The toggle period is
// 64 full scan cycles.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous active-low reset
//   value  in   VAL_W-bit unsigned total, sampled on an accepted load
//   load   in   one-cycle conversion request (ignored while busy)
//   busy   out  high while a conversion is in progress
//   seg    out  segments, active-low, seg[0]=a .. seg[6]=g
//   an     out  digit enables, active-low, an[0] = least-significant digit
module hand_display_mux #(
  parameter int DIGITS      = 2,
  parameter int VAL_W       = 5,
  parameter int REFRESH_DIV = 50000,
  parameter int BUST_LIMIT  = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [VAL_W-1:0]  value,
  input  logic              load,
  output logic              busy,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = VAL_W + BCD_W;
  localparam int CW    = $clog2(VAL_W + 1);
  localparam int RW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 32'd10;
    end
    return p;
  endfunction

  localparam logic [31:0] MAX_VAL = pow10(DIGITS) - 32'd1;

  // Segment vectors are {g,f,e,d,c,b,a}. Each one is the a..g pattern bit-reversed.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1000000;
      4'd1:    c = 7'b1111001;
      4'd2:    c = 7'b0100100;
      4'd3:    c = 7'b0110000;
      4'd4:    c = 7'b0011001;
      4'd5:    c = 7'b0010010;
      4'd6:    c = 7'b0000010;
      4'd7:    c = 7'b1111000;
      4'd8:    c = 7'b0000000;
      4'd9:    c = 7'b0011000;
      default: c = SEG_DASH;
    endcase
    return c;
  endfunction

  // One double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] t;
    t = sr;
    for (int k = 0; k < DIGITS; k++) begin
      if (t[VAL_W+4*k +: 4] >= 4'd5) begin
        t[VAL_W+4*k +: 4] = t[VAL_W+4*k +: 4] + 4'd3;
      end else begin
        t[VAL_W+4*k +: 4] = t[VAL_W+4*k +: 4];
      end
    end
    return {t[SR_W-2:0], 1'b0};
  endfunction

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [SR_W-1:0]   sr_q, sr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]  disp_q, disp_d;
  logic              disp_ovf_q, disp_ovf_d;
  logic              busy_q;
  logic [RW-1:0]     ref_q;
  logic [IW-1:0]     idx_q;
  logic [6:0]        seg_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        dig_code_s [DIGITS];
  logic [6:0]        sel_code_s;
  logic [DIGITS-1:0] sel_an_s;
  logic              slot_wrap_s;
  logic              scan_end_s;

`ifdef HAND_BUST_BLINK_EN
  logic              bust_pend_q, bust_pend_d;
  logic              bust_q, bust_d;
  logic [5:0]        scan_cnt_q;
  logic              blink_q;
`else
  // BUST_LIMIT only matters when blinking is built in.
  localparam int unused_bust_limit = BUST_LIMIT;
`endif

  // Conversion FSM next-state logic. The display only updates on the final shift.
  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    disp_ovf_d = disp_ovf_q;
`ifdef HAND_BUST_BLINK_EN
    bust_pend_d = bust_pend_q;
    bust_d      = bust_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d       = {{BCD_W{1'b0}}, value};
          cnt_d      = CW'(VAL_W);
          ovf_pend_d = (32'(value) > MAX_VAL);
`ifdef HAND_BUST_BLINK_EN
          bust_pend_d = (32'(value) > 32'(BUST_LIMIT));
`endif
          state_d    = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sr_d  = dabble_step(sr_q);
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          disp_d     = sr_d[SR_W-1 -: BCD_W];
          disp_ovf_d = ovf_pend_q;
`ifdef HAND_BUST_BLINK_EN
          bust_d     = bust_pend_q && !ovf_pend_q;
`endif
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Conversion FSM state and display registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef HAND_BUST_BLINK_EN
      bust_pend_q <= 1'b0;
      bust_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      disp_ovf_q <= disp_ovf_d;
      busy_q     <= (state_d == ST_SHIFT);
`ifdef HAND_BUST_BLINK_EN
      bust_pend_q <= bust_pend_d;
      bust_q      <= bust_d;
`endif
    end
  end

  // Per-digit codes. Scan from the top digit downwards so that zeros above the
  // first nonzero digit are blanked. Digit 0 always shows a numeral.
  always_comb begin
    logic nz_above;
    logic [3:0] nib;
    nz_above = 1'b0;
    nib      = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_q[4*i +: 4];
      if (disp_ovf_q) begin
        dig_code_s[i] = SEG_DASH;
      end else if ((i != 0) && !nz_above && (nib == 4'd0)) begin
        dig_code_s[i] = SEG_BLANK;
      end else begin
        dig_code_s[i] = seg_encode(nib);
      end
      if (nib != 4'd0) begin
        nz_above = 1'b1;
      end else begin
        nz_above = nz_above;
      end
    end
  end

  // Select the code and enable pattern for the current scan slot.
  always_comb begin
    sel_code_s = SEG_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sel_code_s = dig_code_s[i];
      end else begin
        sel_code_s = sel_code_s;
      end
    end
    sel_an_s    = ~(DIGITS'(1'b1) << idx_q);
    slot_wrap_s = (ref_q == RW'(REFRESH_DIV - 1));
    scan_end_s  = slot_wrap_s && (idx_q == IW'(DIGITS - 1));
  end

  // Refresh counter, digit index and registered segment/enable outputs.
  // The slot that is latched on a wrap edge belongs to the index that was current before the advance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else if (slot_wrap_s) begin
      ref_q <= '0;
      idx_q <= scan_end_s ? '0 : (idx_q + IW'(1));
      seg_q <= sel_code_s;
`ifdef HAND_BUST_BLINK_EN
      an_q  <= blink_q ? '1 : sel_an_s;
`else
      an_q  <= sel_an_s;
`endif
    end else begin
      ref_q <= ref_q + RW'(1);
    end
  end

`ifdef HAND_BUST_BLINK_EN
  // Blink toggle for bust totals. It flips after every 64 completed scan cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt_q <= 6'd0;
      blink_q    <= 1'b0;
    end else if (!bust_q) begin
      scan_cnt_q <= 6'd0;
      blink_q    <= 1'b0;
    end else if (scan_end_s) begin
      scan_cnt_q <= scan_cnt_q + 6'd1;
      blink_q    <= (scan_cnt_q == 6'd63) ? ~blink_q : blink_q;
    end else begin
      scan_cnt_q <= scan_cnt_q;
      blink_q    <= blink_q;
    end
  end
`endif

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_hand_display_mux.sv
// Testbench for hand_display_mux. It drives two instances from the same
// inputs:
//   dut2: DIGITS=2, VAL_W=5, REFRESH_DIV=4
//   dut1: DIGITS=1, VAL_W=5, REFRESH_DIV=1 (overflow path, one-clock slots)
// The expected busy/seg/an values come from a cycle-level model. The model
// uses decimal arithmetic on the accepted totals and the a..g pattern strings.
module tb_hand_display_mux;

  localparam int VW = 5;
  localparam int D2 = 2;
  localparam int R2 = 4;
  localparam int D1 = 1;
  localparam int R1 = 1;

  logic          clk;
  logic          rst_n;
  logic [VW-1:0] value;
  logic          load;
  logic          busy2, busy1;
  logic [6:0]    seg2, seg1;
  logic [D2-1:0] an2;
  logic [D1-1:0] an1;

  int n_cmp;
  int n_bad;

  // Patterns are written in a..g order (index 0 = segment a).
  string seg_tab [10] = '{"0000001", "1001111", "0010010", "0000110", "1001100",
                          "0100100", "0100000", "0001111", "0000000", "0001100"};

  // Model state
  int         rem;        // remaining busy cycles of the conversion in flight
  int         pend;       // total being converted
  int         disp;       // total currently held for display
  int         k;          // clocks since reset release
  logic       exp_busy;
  logic [6:0] exp_seg2, exp_seg1;
  logic [1:0] exp_an2;
  logic       exp_an1;

  hand_display_mux #(.DIGITS(D2), .VAL_W(VW), .REFRESH_DIV(R2)) dut2 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy2), .seg(seg2), .an(an2)
  );

  hand_display_mux #(.DIGITS(D1), .VAL_W(VW), .REFRESH_DIV(R1)) dut1 (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy1), .seg(seg1), .an(an1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Segment vector (bit 0 = a) expected for decimal digit position dg of total val on nd digits.
  function automatic logic [6:0] exp_code(input int val, input int dg, input int nd);
    int p, pmax;
    string s;
    logic [6:0] r;
    p = 1;
    for (int i = 0; i < dg; i++) p = p * 10;
    pmax = 1;
    for (int i = 0; i < nd; i++) pmax = pmax * 10;
    if (val >= pmax)                s = "1111110";
    else if (dg > 0 && val < p)     s = "1111111";
    else                            s = seg_tab[(val / p) % 10];
    for (int b = 0; b < 7; b++) r[b] = (s[b] == 8'h31);
    return r;
  endfunction

  // Advance the model across one rising edge, using the inputs that were held at that edge.
  task automatic model_edge();
    int dg;
    if (!rst_n) begin
      rem = 0; pend = 0; disp = 0; k = 0;
      exp_seg2 = 7'h7F; exp_an2 = 2'b11;
      exp_seg1 = 7'h7F; exp_an1 = 1'b1;
    end else begin
      k++;
      if (k % R2 == 0) begin
        dg = (k / R2 - 1) % D2;
        exp_seg2 = exp_code(disp, dg, D2);
        exp_an2  = 2'(3 - (1 << dg));
      end
      if (k % R1 == 0) begin
        exp_seg1 = exp_code(disp, 0, D1);
        exp_an1  = 1'b0;
      end
      if (rem == 0) begin
        if (load) begin
          rem  = VW;
          pend = int'(value);
        end
      end else begin
        rem--;
        if (rem == 0) disp = pend;
      end
    end
    exp_busy = (rem > 0);
  endtask

  task automatic cyc(input logic ld, input int v, input logic rn);
    rst_n = rn;
    load  = ld;
    value = VW'(v);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("busy2", 32'(busy2), 32'(exp_busy));
    check_eq("seg2",  32'(seg2),  32'(exp_seg2));
    check_eq("an2",   32'(an2),   32'(exp_an2));
    check_eq("busy1", 32'(busy1), 32'(exp_busy));
    check_eq("seg1",  32'(seg1),  32'(exp_seg1));
    check_eq("an1",   32'(an1),   32'(exp_an1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b1);
  endtask

  task automatic pulse(input int v);
    cyc(1'b1, v, 1'b1);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rem = 0; pend = 0; disp = 0; k = 0;
    exp_busy = 1'b0;
    exp_seg2 = 7'h7F; exp_an2 = 2'b11; exp_seg1 = 7'h7F; exp_an1 = 1'b1;
    rst_n = 1'b0; load = 1'b0; value = '0;
    @(negedge clk);

    // Reset held for three clocks, then the first scan wraps.
    for (int i = 0; i < 3; i++) cyc(1'b0, 0, 1'b0);
    idle(12);

    // Plain conversions, including a blanked upper digit and a zero units digit.
    pulse(17); idle(40);
    pulse(7);  idle(40);
    pulse(20); idle(40);

    // A load during busy is dropped.
    pulse(21); idle(1); pulse(3); idle(40);

    // A load on the completion edge is dropped.
    pulse(9); idle(4); pulse(4); idle(40);

    // Reset in the middle of a conversion.
    pulse(25); idle(1); cyc(1'b0, 0, 1'b0); idle(30);

    pulse(0);  idle(40);
    pulse(31); idle(40);

    // Randomized loads with occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 5) == 0), int'($urandom_range(0, 31)),
          ($urandom_range(0, 199) != 0));
    end
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
